// File: rtl/mul_arbiter.sv
// Two-requester arbiter in front of a single shared multiplier core.
// Define MUL_ARBITER_ROUND_ROBIN_EN for round-robin; default is fixed priority.
module mul_arbiter #(
    parameter int WIDTH = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [WIDTH-1:0]     req0_multiplier,
    input  logic [WIDTH-1:0]     req0_multiplicand,
    input  logic [WIDTH-1:0]     req1_multiplier,
    input  logic [WIDTH-1:0]     req1_multiplicand,
    output logic [1:0]           resp_valid,
    input  logic [1:0]           resp_ready,
    output logic [2*WIDTH-1:0]   resp_result,
    output logic [WIDTH-1:0]     m_multiplier,
    output logic [WIDTH-1:0]     m_multiplicand,
    output logic                 m_op_start,
    output logic                 m_op_clear,
    input  logic                 m_op_done,
    input  logic [2*WIDTH-1:0]   m_result,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        RESP  = 2'd2,
        CLEAR = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 grant_q, grant_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 win;

`ifdef MUL_ARBITER_ROUND_ROBIN_EN
    logic                 last_q, last_d;

    // On contention the requester that was not served last wins.
    always_comb begin
        if (&req_valid) win = ~last_q;
        else            win = ~req_valid[0];
    end
`else
    always_comb win = ~req_valid[0];
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        mplier_d  = mplier_q;
        mcand_d   = mcand_q;
        result_d  = result_q;
        req_ready = 2'b00;
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
        last_d    = last_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_valid && !reset) begin
                    req_ready = win ? 2'b10 : 2'b01;
                    state_d   = BUSY;
                    grant_d   = win;
                    mplier_d  = win ? req1_multiplier : req0_multiplier;
                    mcand_d   = win ? req1_multiplicand : req0_multiplicand;
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
                    last_d    = win;
`endif
                end
            end
            BUSY: begin
                if (m_op_done) begin
                    result_d = m_result;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (resp_ready[grant_q]) state_d = CLEAR;
            end
            CLEAR: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            grant_q  <= 1'b0;
            mplier_q <= '0;
            mcand_q  <= '0;
            result_q <= '0;
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            mplier_q <= mplier_d;
            mcand_q  <= mcand_d;
            result_q <= result_d;
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
            last_q   <= last_d;
`endif
        end
    end

    // The core keeps start high through RESP so it holds its done state.
    assign m_op_start     = (state_q == BUSY) || (state_q == RESP);
    assign m_op_clear     = (state_q == CLEAR);
    assign busy           = (state_q != IDLE);
    assign resp_valid     = (state_q == RESP) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_result    = result_q;
    assign m_multiplier   = mplier_q;
    assign m_multiplicand = mcand_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter with a small behavioural multiplier core.
// Expected products and grant orders are hand-computed constants.
module tb_mul_arbiter;

    localparam int W = 64;

    logic           clk = 1'b0;
    logic           reset;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [W-1:0]   req0_multiplier, req0_multiplicand;
    logic [W-1:0]   req1_multiplier, req1_multiplicand;
    logic [1:0]     resp_valid;
    logic [1:0]     resp_ready;
    logic [2*W-1:0] resp_result;
    logic [W-1:0]   m_multiplier, m_multiplicand;
    logic           m_op_start, m_op_clear;
    logic           m_op_done;
    logic [2*W-1:0] m_result;
    logic           busy;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mul_arbiter #(.WIDTH(W)) dut (
        .clk               (clk),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req0_multiplier   (req0_multiplier),
        .req0_multiplicand (req0_multiplicand),
        .req1_multiplier   (req1_multiplier),
        .req1_multiplicand (req1_multiplicand),
        .resp_valid        (resp_valid),
        .resp_ready        (resp_ready),
        .resp_result       (resp_result),
        .m_multiplier      (m_multiplier),
        .m_multiplicand    (m_multiplicand),
        .m_op_start        (m_op_start),
        .m_op_clear        (m_op_clear),
        .m_op_done         (m_op_done),
        .m_result          (m_result),
        .busy              (busy)
    );

    // Core: done after four cycles of start, held until clear.
    logic [2:0] core_cnt;
    always_ff @(posedge clk) begin
        if (reset || m_op_clear)             core_cnt <= 3'd0;
        else if (m_op_start && core_cnt != 3'd4) core_cnt <= core_cnt + 3'd1;
    end
    assign m_op_done = m_op_start && (core_cnt == 3'd4);
    assign m_result  = {{W{1'b0}}, m_multiplier} * {{W{1'b0}}, m_multiplicand};

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    // Entered at sample point k=1 after acceptance; waits for the response.
    task automatic wait_resp(input string tag);
        int n = 1;
        while (resp_valid == 2'b00 && n < 30) begin
            @(negedge clk); #1;
            n++;
        end
        chk({tag, "_lat"}, n, 6);
    endtask

    task automatic do_op(input logic id, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [127:0] exp,
                         input string tag);
        if (id) begin
            req1_multiplier = a; req1_multiplicand = b;
        end else begin
            req0_multiplier = a; req0_multiplicand = b;
        end
        req_valid = id ? 2'b10 : 2'b01;
        #1;
        chk({tag, "_rdy"}, req_ready, id ? 2'b10 : 2'b01);
        @(negedge clk);
        req_valid = 2'b00;
        #1;
        chk({tag, "_start"}, {m_op_start, busy, req_ready}, 4'b1100);
        chk({tag, "_ops"}, {m_multiplier, m_multiplicand}, {a, b});
        wait_resp(tag);
        chk({tag, "_rv"}, resp_valid, id ? 2'b10 : 2'b01);
        chk({tag, "_res"}, resp_result, exp);
        resp_ready = id ? 2'b10 : 2'b01;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk({tag, "_clr"}, {m_op_clear, m_op_start, resp_valid}, 4'b1000);
        @(negedge clk); #1;
        chk({tag, "_idle"}, {busy, m_op_clear}, 2'b00);
        chk({tag, "_hold"}, {m_multiplier, m_multiplicand}, {a, b});
    endtask

    initial begin
        logic [1:0] exp_g [4];
        int n;
        reset = 1'b1;
        req_valid = 2'b01;
        resp_ready = 2'b00;
        req0_multiplier = 64'd1; req0_multiplicand = 64'd1;
        req1_multiplier = 64'd1; req1_multiplicand = 64'd1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_ctrl", {req_ready, resp_valid, m_op_start, m_op_clear, busy},
            7'b0);
        chk("rst_data", {resp_result, m_multiplier, m_multiplicand}, 0);
        reset = 1'b0;
        req_valid = 2'b00;
        @(negedge clk); #1;

        do_op(1'b0, 64'd3, 64'd5, 128'd15, "single");

        // Back-pressure plus wrong-port ready
        req1_multiplier = 64'd9; req1_multiplicand = 64'd11;
        req_valid = 2'b10;
        #1;
        chk("bp_rdy", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b01;
        #1;
        wait_resp("bp");
        chk("bp_res0", resp_result, 128'd99);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            chk("bp_ctl", {resp_valid, m_op_start, m_op_clear, req_ready},
                6'b10_1_0_00);
            chk("bp_res", resp_result, 128'd99);
        end
        req_valid = 2'b00;
        resp_ready = 2'b01;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("wrong_port", {resp_valid, busy, m_op_clear}, 4'b1010);
        resp_ready = 2'b10;
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("bp_clr", {m_op_clear, m_op_start}, 2'b10);
        @(negedge clk); #1;
        chk("bp_idle", busy, 1'b0);

        // Simultaneous requests, last grant was requester 1
`ifdef MUL_ARBITER_ROUND_ROBIN_EN
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
        exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
        req0_multiplier = 64'd7; req0_multiplicand = 64'd7;
        req1_multiplier = 64'd2; req1_multiplicand = 64'd9;
        req_valid = 2'b11;
        resp_ready = 2'b11;
        #1;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (req_ready == 2'b00 && n < 30) begin
                @(negedge clk); #1;
                n++;
            end
            chk("sim_grant", req_ready, exp_g[i]);
            @(negedge clk); #1;
            n = 0;
            while (resp_valid == 2'b00 && n < 30) begin
                @(negedge clk); #1;
                n++;
            end
            chk("sim_rv", resp_valid, exp_g[i]);
            chk("sim_res", resp_result, exp_g[i] == 2'b01 ? 128'd49 : 128'd18);
            if (i == 3) req_valid = 2'b00;
            @(negedge clk); #1;
        end
        @(negedge clk);
        resp_ready = 2'b00;
        #1;
        chk("sim_idle", busy, 1'b0);

        do_op(1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
              128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, "full");

        // Reset two cycles after acceptance
        req1_multiplier = 64'd5; req1_multiplicand = 64'd6;
        req_valid = 2'b10;
        #1;
        chk("rb_rdy", req_ready, 2'b10);
        @(negedge clk);
        req_valid = 2'b00;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rb_ctl", {busy, m_op_start, m_op_clear, resp_valid}, 5'b0);
        n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (resp_valid != 2'b00 || busy) n++;
        end
        chk("rb_noresp", n, 0);
        do_op(1'b0, 64'd6, 64'd7, 128'd42, "after_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
